// File: rtl/ctrl_seq_mc.sv
// ctrl_seq_mc: URCPU multi-cycle control sequencer stepping FETCH/DECODE/EXECUTE/MEM/WRITE_BACK.
// Define CTRL_TIMEOUT_EN to enable the memory-wait timeout counter and the FAULT state.
module ctrl_seq_mc #(
    parameter int unsigned         OPCODE_W    = 6,
    parameter logic [OPCODE_W-1:0] OP_LOAD     = 6'h23,
    parameter logic [OPCODE_W-1:0] OP_STORE    = 6'h2B,
    parameter logic [OPCODE_W-1:0] OP_BRANCH   = 6'h04,
    parameter logic [OPCODE_W-1:0] OP_HALT     = 6'h3F,
    parameter logic [OPCODE_W-1:0] OP_NOP      = 6'h00,
    parameter int unsigned         TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic                fetch,
    output logic                decode,
    output logic                execute,
    output logic                mem_access,
    output logic                write_back,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                reg_we,
    output logic                retire,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMem, StWriteBack, StHalt, StFault
    } state_e;

    typedef enum logic [1:0] {ClsAlu, ClsLoad, ClsStore, ClsBranch} cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        retire  = 1'b0;
        case (state_q)
            StIdle: if (start) state_d = StFetch;
            StFetch: begin
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode == OP_LOAD)        cls_d = ClsLoad;
                else if (opcode == OP_STORE)  cls_d = ClsStore;
                else if (opcode == OP_BRANCH) cls_d = ClsBranch;
                else                          cls_d = ClsAlu;
                if (opcode == OP_NOP) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (opcode == OP_HALT) begin
                    retire  = 1'b1;
                    state_d = StHalt;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                case (cls_q)
                    ClsBranch: begin
                        pc_load = branch_taken;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsLoad, ClsStore: state_d = StMem;
                    default:           state_d = StWriteBack;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (cls_q == ClsStore) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteBack;
                    end
                end
            end
            StWriteBack: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt:  if (start) state_d = StFetch;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase

`ifdef CTRL_TIMEOUT_EN
        // A ready cycle never counts as a wait, so mem_ready beats an expiring timeout.
        cnt_d = cnt_q;
        if ((state_q == StFetch || state_q == StMem) && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(TIMEOUT_CYC)) state_d = StFault;
        end else if (state_d != state_q) begin
            cnt_d = '0;
        end
`endif
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cls_q      <= ClsAlu;
            fetch      <= 1'b0;
            decode     <= 1'b0;
            execute    <= 1'b0;
            mem_access <= 1'b0;
            write_back <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            reg_we     <= 1'b0;
            halted     <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            cnt_q      <= '0;
            fault      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            fetch      <= (state_d == StFetch);
            decode     <= (state_d == StDecode);
            execute    <= (state_d == StExecute);
            mem_access <= (state_d == StMem);
            write_back <= (state_d == StWriteBack);
            mem_req    <= (state_d == StFetch) || (state_d == StMem);
            mem_we     <= (state_d == StMem) && (cls_d == ClsStore);
            reg_we     <= (state_d == StWriteBack);
            halted     <= (state_d == StHalt);
`ifdef CTRL_TIMEOUT_EN
            cnt_q      <= cnt_d;
            fault      <= (state_d == StFault);
`endif
        end
    end

`ifndef CTRL_TIMEOUT_EN
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_seq_mc.sv
// Bench for ctrl_seq_mc: directed vector table, async-reset/timeout sequences, random traces.
module tb_ctrl_seq_mc;

    localparam logic [5:0] OP_LOAD = 6'h23, OP_STORE = 6'h2B, OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_HALT = 6'h3F, OP_NOP = 6'h00;

    // Output bit positions: fetch..fault packed MSB to LSB.
    localparam logic [13:0] S_F   = 14'h2000, S_DEC = 14'h1000, S_EXE = 14'h0800;
    localparam logic [13:0] S_MEM = 14'h0400, S_WB  = 14'h0200, S_REQ = 14'h0100;
    localparam logic [13:0] S_WE  = 14'h0080, S_IRL = 14'h0040, S_PCI = 14'h0020;
    localparam logic [13:0] S_PCL = 14'h0010, S_RWE = 14'h0008, S_RET = 14'h0004;
    localparam logic [13:0] S_HLT = 14'h0002, S_FLT = 14'h0001;
    localparam logic [13:0] S_FDONE = S_F | S_REQ | S_IRL | S_PCI;

    logic       clk, reset_n, start, mem_ready, branch_taken;
    logic [5:0] opcode;
    logic fetch, decode, execute, mem_access, write_back, mem_req, mem_we;
    logic ir_load, pc_inc, pc_load, reg_we, retire, halted, fault;
    logic [13:0] outs;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        st;
        logic        rdy;
        logic        bt;
        logic [5:0]  op;
        logic [13:0] exp;
    } vec_t;

    vec_t q[$];

    ctrl_seq_mc #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .fetch(fetch), .decode(decode), .execute(execute), .mem_access(mem_access),
        .write_back(write_back), .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we), .retire(retire),
        .halted(halted), .fault(fault)
    );

    assign outs = {fetch, decode, execute, mem_access, write_back, mem_req, mem_we,
                   ir_load, pc_inc, pc_load, reg_we, retire, halted, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic st, input logic rdy, input logic bt, input logic [5:0] op,
                       input logic [13:0] e);
        vec_t v;
        v.st = st; v.rdy = rdy; v.bt = bt; v.op = op; v.exp = e;
        q.push_back(v);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // Reference trace of one instruction built from its stage list, starting in FETCH.
    task automatic gen_instr(input logic [5:0] op, input int wf, input int wm);
        logic bt;
        logic [13:0] we;
        for (int i = 0; i < wf; i++) add(rb(), 1'b0, rb(), rop(), S_F | S_REQ);
        add(rb(), 1'b1, rb(), rop(), S_FDONE);
        if (op == OP_NOP || op == OP_HALT) begin
            add(rb(), rb(), rb(), op, S_DEC | S_RET);
            return;
        end
        add(rb(), rb(), rb(), op, S_DEC);
        if (op == OP_BRANCH) begin
            bt = rb();
            add(rb(), rb(), bt, rop(), S_EXE | S_RET | (bt ? S_PCL : 14'h0));
            return;
        end
        add(rb(), rb(), rb(), rop(), S_EXE);
        if (op == OP_LOAD || op == OP_STORE) begin
            we = (op == OP_STORE) ? S_WE : 14'h0;
            for (int i = 0; i < wm; i++) add(rb(), 1'b0, rb(), rop(), S_MEM | S_REQ | we);
            add(rb(), 1'b1, rb(), rop(), S_MEM | S_REQ | we | ((op == OP_STORE) ? S_RET : 14'h0));
            if (op == OP_STORE) return;
        end
        add(rb(), rb(), rb(), rop(), S_WB | S_RWE | S_RET);
    endtask

    task automatic run_queue(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            start = q[i].st; mem_ready = q[i].rdy; branch_taken = q[i].bt; opcode = q[i].op;
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), outs, q[i].exp);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] op;
        int kind;

        // Directed vector table: {start, mem_ready, branch_taken, opcode, expected outputs}.
        add(0, 0, 0, 6'h00, 14'h0);
        add(0, 1, 1, 6'h00, 14'h0);
        add(1, 0, 0, 6'h20, 14'h0);
        add(0, 1, 0, 6'h20, S_FDONE);
        add(0, 0, 0, 6'h20, S_DEC);
        add(0, 0, 0, 6'h20, S_EXE);
        add(0, 0, 0, 6'h20, S_WB | S_RWE | S_RET);
        add(0, 1, 0, OP_LOAD, S_FDONE);
        add(0, 0, 0, OP_LOAD, S_DEC);
        add(0, 0, 0, OP_LOAD, S_EXE);
        for (int i = 0; i < 3; i++) add(0, 0, 0, OP_LOAD, S_MEM | S_REQ);
        add(0, 1, 0, OP_LOAD, S_MEM | S_REQ);
        add(0, 0, 0, OP_LOAD, S_WB | S_RWE | S_RET);
        add(0, 1, 0, OP_STORE, S_FDONE);
        add(0, 0, 0, OP_STORE, S_DEC);
        add(0, 0, 0, OP_STORE, S_EXE);
        add(0, 1, 0, OP_STORE, S_MEM | S_REQ | S_WE | S_RET);
        add(0, 1, 0, OP_BRANCH, S_FDONE);
        add(0, 0, 0, OP_BRANCH, S_DEC);
        add(0, 0, 1, OP_BRANCH, S_EXE | S_PCL | S_RET);
        add(0, 1, 1, OP_BRANCH, S_FDONE);
        add(0, 0, 1, OP_BRANCH, S_DEC);
        add(0, 0, 0, OP_BRANCH, S_EXE | S_RET);
        add(0, 1, 0, OP_NOP, S_FDONE);
        add(0, 0, 0, OP_NOP, S_DEC | S_RET);
        add(0, 1, 0, OP_HALT, S_FDONE);
        add(0, 0, 0, OP_HALT, S_DEC | S_RET);
        for (int i = 0; i < 10; i++) add(0, 1'(i & 1), 1, OP_HALT, S_HLT);
        add(1, 0, 0, OP_HALT, S_HLT);
        add(0, 0, 0, OP_LOAD, S_F | S_REQ);
        add(0, 1, 0, OP_LOAD, S_FDONE);
        add(0, 0, 0, OP_LOAD, S_DEC);
        add(0, 0, 0, OP_LOAD, S_EXE);
        add(0, 0, 0, OP_LOAD, S_MEM | S_REQ);

        reset_n = 1'b0; start = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", outs, 14'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_queue("dir");

        // Still in MEM: asynchronous reset must clear outputs without a clock edge.
        reset_n = 1'b0;
        #1;
        check("async_reset", outs, 14'h0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold", outs, 14'h0);
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("release_idle", outs, 14'h0);
        @(posedge clk);
        #1;

        add(1, 0, 0, 6'h00, 14'h0);
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 4; i++) add(rb(), 0, rb(), rop(), S_F | S_REQ);
        for (int i = 0; i < 6; i++) add(1, rb(), rb(), rop(), S_FLT);
`else
        for (int i = 0; i < 100; i++) add(rb(), 0, rb(), rop(), S_F | S_REQ);
`endif
        run_queue("stall");

        do_reset();
        add(1, rb(), rb(), rop(), 14'h0);
        gen_instr(6'h11, 3, 0);
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                3:       op = OP_LOAD;
                4:       op = OP_STORE;
                5, 6:    op = OP_BRANCH;
                7:       op = OP_NOP;
                8:       op = OP_HALT;
                default: begin
                    op = rop();
                    while (op == OP_LOAD || op == OP_STORE || op == OP_BRANCH ||
                           op == OP_HALT || op == OP_NOP) op = rop();
                end
            endcase
            gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            if (op == OP_HALT) begin
                for (int i = 0; i < $urandom_range(0, 3); i++) add(0, rb(), rb(), rop(), S_HLT);
                add(1, rb(), rb(), rop(), S_HLT);
            end
        end
        run_queue("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
